// File: rtl/kv_hash_table_if.sv
// kv_hash_table_if: request/reply bundle between the DNS-filter packet parser
// and the key/status store. The parser drives requests (master side) and the
// store returns one reply per request (slave side).
interface kv_hash_table_if #(
  parameter int KEY_SIZE = 96
);
  logic [KEY_SIZE-1:0] in_key;
  logic [3:0]          in_flag;
  logic                in_valid;
  logic                out_valid;
  logic [3:0]          out_flag;

  modport master (
    output in_key,
    output in_flag,
    output in_valid,
    input  out_valid,
    input  out_flag
  );

  modport slave (
    input  in_key,
    input  in_flag,
    input  in_valid,
    output out_valid,
    output out_flag
  );
endinterface

// File: rtl/kv_hash_table.sv
// kv_hash_table: direct-mapped, hash-indexed key/status store for per-flow
// SUSPECT / ARREST tracking. Accepts one request per cycle and answers each
// one exactly three cycles later. After reset the RAM is swept to all-zero
// entries; requests arriving during the sweep get an empty reply.
// Optional feature macro: KVS_AGING_EN (per-entry timestamps, stale entries
// behave as misses).
module kv_hash_table #(
  parameter int KEY_SIZE = 96,
  parameter int RAM_ADDR = 10
`ifdef KVS_AGING_EN
  ,
  parameter int          VAL_SIZE    = 32,
  parameter logic [31:0] AGE_TIMEOUT = 32'd156250000
`endif
) (
  input  logic           clk156,
  input  logic           eth_rst,
  kv_hash_table_if.slave bus,
  output logic           init_done,
  output logic [7:0]     debug
);

  localparam int DEPTH  = 1 << RAM_ADDR;
  localparam int NCHUNK = (KEY_SIZE + RAM_ADDR - 1) / RAM_ADDR;
  localparam int PAD_W  = NCHUNK * RAM_ADDR;
`ifdef KVS_AGING_EN
  localparam int KEY_LSB = VAL_SIZE;
`else
  localparam int KEY_LSB = 0;
`endif
  // Entry layout, MSB first: {valid, status[1:0], key[, ts]}
  localparam int ENT_W = KEY_LSB + KEY_SIZE + 3;

  localparam logic [1:0] STAT_SUSPECT = 2'b01;
  localparam logic [1:0] STAT_ARREST  = 2'b10;
  localparam logic [1:0] OP_SUSPECT   = 2'b01;
  localparam logic [1:0] OP_ARREST    = 2'b10;
  localparam logic [RAM_ADDR-1:0] LAST_ADDR = RAM_ADDR'(DEPTH - 1);

  // XOR-fold of the zero-extended key into RAM_ADDR-bit chunks
  function automatic logic [RAM_ADDR-1:0] hash_key(input logic [KEY_SIZE-1:0] key);
    logic [PAD_W-1:0]    padded;
    logic [RAM_ADDR-1:0] acc;
    padded = PAD_W'(key);
    acc    = {RAM_ADDR{1'b0}};
    for (int i = 0; i < NCHUNK; i++) begin
      acc = acc ^ padded[i*RAM_ADDR +: RAM_ADDR];
    end
    return acc;
  endfunction

  typedef enum logic [0:0] {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [RAM_ADDR-1:0] sweep_addr_q, sweep_addr_d;
  logic                init_done_q, init_done_d;
  logic                sweep_we_s;

  logic [ENT_W-1:0]    mem_q [0:DEPTH-1];
  logic [ENT_W-1:0]    rd_data_q;

  logic                s1_valid_q, s1_init_q;
  logic [KEY_SIZE-1:0] s1_key_q;
  logic [2:0]          s1_flag_q;
  logic [RAM_ADDR-1:0] s1_hash_q;

  logic                s2_valid_q, s2_init_q;
  logic [KEY_SIZE-1:0] s2_key_q;
  logic [2:0]          s2_flag_q;
  logic [RAM_ADDR-1:0] s2_hash_q;

  logic                byp_valid_q;
  logic [RAM_ADDR-1:0] byp_addr_q;
  logic [ENT_W-1:0]    byp_data_q;

  logic                out_valid_q;
  logic [3:0]          out_flag_q;
  logic [3:0]          evict_q;
  logic                arrest_q;

  logic [ENT_W-1:0]    ent_s;
  logic                e_valid_s, expired_s, live_s, hit_s;
  logic [1:0]          e_status_s, new_status_s;
  logic [KEY_SIZE-1:0] e_key_s;
  logic                req_we_s, evict_s, arrest_s;
  logic [3:0]          reply_s;
  logic [ENT_W-1:0]    req_wdata_s;

  logic                ram_we_s;
  logic [RAM_ADDR-1:0] ram_waddr_s;
  logic [ENT_W-1:0]    ram_wdata_s;

`ifdef KVS_AGING_EN
  logic [VAL_SIZE-1:0] age_cnt_q;
  logic [VAL_SIZE-1:0] age_s;

  // Free-running timestamp counter
  always_ff @(posedge clk156) begin
    if (eth_rst) begin
      age_cnt_q <= {VAL_SIZE{1'b0}};
    end else begin
      age_cnt_q <= age_cnt_q + VAL_SIZE'(1);
    end
  end
`endif

  // Sweep FSM state register
  always_ff @(posedge clk156) begin
    if (eth_rst) begin
      state_q      <= S_INIT;
      sweep_addr_q <= {RAM_ADDR{1'b0}};
      init_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_addr_q <= sweep_addr_d;
      init_done_q  <= init_done_d;
    end
  end

  // Sweep FSM: clear one address per cycle, then run forever
  always_comb begin
    state_d      = state_q;
    sweep_addr_d = sweep_addr_q;
    init_done_d  = init_done_q;
    sweep_we_s   = 1'b0;
    case (state_q)
      S_INIT: begin
        sweep_we_s   = 1'b1;
        sweep_addr_d = sweep_addr_q + RAM_ADDR'(1);
        if (sweep_addr_q == LAST_ADDR) begin
          state_d     = S_RUN;
          init_done_d = 1'b1;
        end else begin
          state_d     = S_INIT;
        end
      end
      S_RUN: begin
        state_d     = S_RUN;
        init_done_d = 1'b1;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  // Stage 1: capture request and its hash; tag requests seen before init completes
  always_ff @(posedge clk156) begin
    if (eth_rst) begin
      s1_valid_q <= 1'b0;
      s1_init_q  <= 1'b0;
      s1_key_q   <= {KEY_SIZE{1'b0}};
      s1_flag_q  <= 3'b000;
      s1_hash_q  <= {RAM_ADDR{1'b0}};
    end else begin
      s1_valid_q <= bus.in_valid;
      s1_init_q  <= ~init_done_q;
      s1_key_q   <= bus.in_key;
      s1_flag_q  <= bus.in_flag[2:0];
      s1_hash_q  <= hash_key(bus.in_key);
    end
  end

  // Single-port-per-direction RAM, read-first
  always_ff @(posedge clk156) begin
    if (ram_we_s) begin
      mem_q[ram_waddr_s] <= ram_wdata_s;
    end
    rd_data_q <= mem_q[s1_hash_q];
  end

  // Stage 2: carry the request alongside the RAM read data
  always_ff @(posedge clk156) begin
    if (eth_rst) begin
      s2_valid_q <= 1'b0;
      s2_init_q  <= 1'b0;
      s2_key_q   <= {KEY_SIZE{1'b0}};
      s2_flag_q  <= 3'b000;
      s2_hash_q  <= {RAM_ADDR{1'b0}};
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_init_q  <= s1_init_q;
      s2_key_q   <= s1_key_q;
      s2_flag_q  <= s1_flag_q;
      s2_hash_q  <= s1_hash_q;
    end
  end

  // Stage 2 lookup: pick bypass or RAM data, decide write and reply
  always_comb begin
    ent_s        = (byp_valid_q && (byp_addr_q == s2_hash_q)) ? byp_data_q : rd_data_q;
    e_valid_s    = ent_s[ENT_W-1];
    e_status_s   = ent_s[ENT_W-2 -: 2];
    e_key_s      = ent_s[KEY_LSB +: KEY_SIZE];
`ifdef KVS_AGING_EN
    age_s        = age_cnt_q - ent_s[VAL_SIZE-1:0];
    expired_s    = (age_s > VAL_SIZE'(AGE_TIMEOUT));
`else
    expired_s    = 1'b0;
`endif
    live_s       = e_valid_s & ~expired_s;
    hit_s        = live_s && (e_key_s == s2_key_q);
    req_we_s     = 1'b0;
    new_status_s = STAT_SUSPECT;
    reply_s      = 4'b0001;
    evict_s      = 1'b0;
    arrest_s     = 1'b0;
    if (s2_valid_q && !s2_init_q && s2_flag_q[0]) begin
      case (s2_flag_q[2:1])
        OP_SUSPECT: begin
          if (hit_s) begin
            reply_s      = {1'b1, e_status_s, 1'b1};
`ifdef KVS_AGING_EN
            req_we_s     = 1'b1;
            new_status_s = e_status_s;
`endif
          end else begin
            req_we_s     = 1'b1;
            new_status_s = STAT_SUSPECT;
            reply_s      = 4'b0011;
            evict_s      = live_s;
          end
        end
        OP_ARREST: begin
          if (hit_s) begin
            req_we_s     = 1'b1;
            new_status_s = STAT_ARREST;
            reply_s      = 4'b1111;
            arrest_s     = 1'b1;
          end else begin
            reply_s      = 4'b0001;
          end
        end
        default: begin
          reply_s = 4'b0001;
        end
      endcase
    end else begin
      reply_s = 4'b0001;
    end
`ifdef KVS_AGING_EN
    req_wdata_s = {1'b1, new_status_s, s2_key_q, age_cnt_q};
`else
    req_wdata_s = {1'b1, new_status_s, s2_key_q};
`endif
  end

  // RAM write port: sweep and request writes never overlap
  always_comb begin
    ram_we_s    = sweep_we_s | req_we_s;
    ram_waddr_s = sweep_we_s ? sweep_addr_q : s2_hash_q;
    ram_wdata_s = sweep_we_s ? {ENT_W{1'b0}} : req_wdata_s;
  end

  // Reply, statistics and write-bypass registers
  always_ff @(posedge clk156) begin
    if (eth_rst) begin
      out_valid_q <= 1'b0;
      out_flag_q  <= 4'b0000;
      evict_q     <= 4'b0000;
      arrest_q    <= 1'b0;
      byp_valid_q <= 1'b0;
      byp_addr_q  <= {RAM_ADDR{1'b0}};
      byp_data_q  <= {ENT_W{1'b0}};
    end else begin
      out_valid_q <= s2_valid_q;
      out_flag_q  <= s2_valid_q ? reply_s : 4'b0000;
      if (evict_s && (evict_q != 4'hF)) begin
        evict_q <= evict_q + 4'd1;
      end else begin
        evict_q <= evict_q;
      end
      arrest_q    <= arrest_q | arrest_s;
      byp_valid_q <= req_we_s;
      byp_addr_q  <= s2_hash_q;
      byp_data_q  <= req_wdata_s;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_flag  = out_flag_q;
  assign init_done     = init_done_q;
  assign debug         = {3'b000, arrest_q, evict_q};

endmodule

// File: tb/tb_kv_hash_table.sv
// tb_kv_hash_table: scoreboard bench for kv_hash_table. Each request pushes
// its required reply and due cycle; a monitor pops and compares on out_valid.
module tb_kv_hash_table;

  logic       clk156 = 1'b0;
  logic       eth_rst;
  logic       init_done;
  logic [7:0] debug;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  typedef struct {
    logic [3:0] flag;
    int         due;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  localparam logic [95:0] K  = 96'h0A00_0001_0A00_0002_3039_0000;
  localparam logic [95:0] K2 = 96'h7;
  localparam logic [95:0] K6 = 96'h9;

  kv_hash_table_if #(.KEY_SIZE(96)) bus ();

  kv_hash_table #(
    .KEY_SIZE(96),
    .RAM_ADDR(10)
`ifdef KVS_AGING_EN
    ,
    .VAL_SIZE(32),
    .AGE_TIMEOUT(32'd100)
`endif
  ) dut (
    .clk156   (clk156),
    .eth_rst  (eth_rst),
    .bus      (bus),
    .init_done(init_done),
    .debug    (debug)
  );

  always #5 clk156 = ~clk156;

  always @(posedge clk156) cyc <= cyc + 1;

  // Scoreboard monitor: compare every reply against the queue head
  initial begin
    forever begin
      @(negedge clk156);
      if (eth_rst === 1'b0) begin
        if (bus.out_valid === 1'b1) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_reply: out_flag=%b at cycle %0d, none required", bus.out_flag, cyc);
          end else begin
            mon_e = exp_q.pop_front();
            if (bus.out_flag !== mon_e.flag || cyc != mon_e.due) begin
              n_bad++;
              $display("FAIL %s: out_flag=%b at cycle %0d, required %b at cycle %0d",
                       mon_e.name, bus.out_flag, cyc, mon_e.flag, mon_e.due);
            end
          end
        end else if (exp_q.size() > 0 && cyc >= exp_q[0].due) begin
          mon_e = exp_q.pop_front();
          n_cmp++;
          n_bad++;
          $display("FAIL %s: no reply at cycle %0d, required %b", mon_e.name, cyc, mon_e.flag);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [95:0] key, input logic [3:0] flag,
                      input logic [3:0] exp, input string name);
    exp_t e;
    bus.in_key   = key;
    bus.in_flag  = flag;
    bus.in_valid = 1'b1;
    e.flag = exp;
    e.due  = cyc + 3;
    e.name = name;
    exp_q.push_back(e);
    @(negedge clk156);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk156);
  endtask

  task automatic test_reset;
    int   early;
    exp_t e;
    early        = -1;
    eth_rst      = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_key   = 96'h0;
    bus.in_flag  = 4'b0000;
    repeat (4) @(negedge clk156);
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.out_flag !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_out: out_valid=%b out_flag=%b, required 0/0000", bus.out_valid, bus.out_flag);
    end
    n_cmp++;
    if (init_done !== 1'b0 || debug !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_status: init_done=%b debug=%h, required 0/00", init_done, debug);
    end
    eth_rst = 1'b0;
    for (int i = 0; i < 1023; i++) begin
      @(negedge clk156);
      if (init_done !== 1'b0 && early < 0) early = i;
      if (i == 4) begin
        bus.in_key   = K;
        bus.in_flag  = 4'b0011;
        bus.in_valid = 1'b1;
        e.flag = 4'b0001;
        e.due  = cyc + 3;
        e.name = "init_request";
        exp_q.push_back(e);
      end else if (i == 5) begin
        bus.in_valid = 1'b0;
      end
    end
    n_cmp++;
    if (early != -1) begin
      n_bad++;
      $display("FAIL init_done_early: rose after %0d cycles, required after 1024", early + 1);
    end
    @(negedge clk156);
    n_cmp++;
    if (init_done !== 1'b1) begin
      n_bad++;
      $display("FAIL init_done_rise: init_done=%b after 1024 cycles, required 1", init_done);
    end
    idle(2);
  endtask

  task automatic test_suspect_arrest;
    send(K, 4'b0011, 4'b0011, "suspect_first");   idle(4);
    send(K, 4'b0011, 4'b1011, "suspect_repeat");  idle(4);
    send(K, 4'b0101, 4'b1111, "arrest_hit");      idle(4);
    send(K, 4'b0011, 4'b1101, "suspect_arrested"); idle(4);
    send(K, 4'b0111, 4'b0001, "op11");            idle(4);
    send(K, 4'b0001, 4'b0001, "op00");            idle(4);
    send(K, 4'b1011, 4'b1101, "flag3_ignored");   idle(4);
    send(96'h6, 4'b0010, 4'b0001, "no_marker");   idle(4);
    send(96'h6, 4'b0011, 4'b0011, "no_marker_nowrite"); idle(4);
    n_cmp++;
    if (debug !== 8'h10) begin
      n_bad++;
      $display("FAIL debug_after_arrest: debug=%h, required 10", debug);
    end
  endtask

  task automatic test_arrest_miss;
    send(96'h5, 4'b0101, 4'b0001, "arrest_miss");       idle(4);
    send(96'h5, 4'b0011, 4'b0011, "suspect_after_miss"); idle(4);
    n_cmp++;
    if (debug !== 8'h10) begin
      n_bad++;
      $display("FAIL debug_arrest_miss: debug=%h, required 10", debug);
    end
  endtask

  task automatic test_back_to_back;
    send(K2, 4'b0011, 4'b0011, "b2b_suspect");
    send(K2, 4'b0101, 4'b1111, "b2b_arrest");
    send(K2, 4'b0011, 4'b1101, "b2b_suspect2");
    idle(5);
  endtask

  task automatic test_aging;
    send(K6, 4'b0011, 4'b0011, "age_first");
    idle(150);
`ifdef KVS_AGING_EN
    send(K6, 4'b0011, 4'b0011, "age_expired");
`else
    send(K6, 4'b0011, 4'b1011, "age_persist");
`endif
    idle(5);
    n_cmp++;
    if (debug !== 8'h10) begin
      n_bad++;
      $display("FAIL debug_aging: debug=%h, required 10", debug);
    end
  endtask

  task automatic test_collision;
    send(96'h401, 4'b0011, 4'b0011, "coll_a"); idle(4);
    send(96'h802, 4'b0011, 4'b0011, "coll_b"); idle(4);
    n_cmp++;
    if (debug !== 8'h11) begin
      n_bad++;
      $display("FAIL evict_one: debug=%h, required 11", debug);
    end
    send(96'h401, 4'b0011, 4'b0011, "coll_a_again"); idle(4);
    n_cmp++;
    if (debug !== 8'h12) begin
      n_bad++;
      $display("FAIL evict_two: debug=%h, required 12", debug);
    end
    for (int i = 0; i < 15; i++) begin
      if (i % 2 == 0) send(96'h802, 4'b0011, 4'b0011, "coll_b2b");
      else            send(96'h401, 4'b0011, 4'b0011, "coll_b2b");
    end
    idle(5);
    n_cmp++;
    if (debug !== 8'h1F) begin
      n_bad++;
      $display("FAIL evict_saturate: debug=%h, required 1f", debug);
    end
  endtask

  initial begin
    test_reset();
    test_suspect_arrest();
    test_arrest_miss();
    test_back_to_back();
    test_aging();
    test_collision();
    idle(4);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d replies outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/kv_hash_table.md
Name: kv_hash_table

Overview:
Key/status store that serves the DNS-filter packet parser's database request port. It consumes one request per cycle (key, flag, valid) and returns one reply per request (valid, flag) a fixed 3 cycles later. Storage is a direct-mapped, hash-indexed single-clock RAM. It tracks per-flow status (SUSPECT / ARREST) so the parser can block packets of flows that ICMP port-unreachable feedback has flagged.

Parameters:
KEY_SIZE, 96, request key width (src IP, dst IP, dst port, pad)
VAL_SIZE, 32, timestamp width stored per entry (aging only)
RAM_ADDR, 10, log2 of entry count (1024 entries)
AGE_TIMEOUT, 32'd156250000, aging limit in clk156 cycles (1 s)

Ports:
clk156  in  1  sole clock
eth_rst  in  1  synchronous active-high reset
in_key  in  KEY_SIZE  request key
in_flag  in  4  [0]=request marker, [2:1]=op (01 SUSPECT, 10 ARREST), [3] ignored
in_valid  in  1  request strobe, one cycle per request, no backpressure
out_valid  out  1  reply strobe
out_flag  out  4  [0]=1 on reply, [2:1]=result status, [3]=key matched
init_done  out  1  high once RAM clear sweep is finished
debug  out  8  [3:0] eviction count (saturating), [4] any ARREST stored, [7:5] 0

Behaviour:
- Reset: out_valid=0, out_flag=0, init_done=0, debug=0, pipeline valids cleared, sweep address=0. Any in-flight request is dropped and gets no reply.
- INIT: after reset release, write the all-zero entry to addresses 0..2^RAM_ADDR-1, one per cycle. init_done rises the cycle after the last write (1024 cycles after reset release).
- Requests accepted during INIT: replied at normal latency with out_flag=4'b0001, no write.
- Entry format: {valid, status[1:0], key[KEY_SIZE-1:0]} (+ts when aging is compiled in).
- Hash: zero-extend key to a multiple of RAM_ADDR bits, then XOR all RAM_ADDR-bit chunks (chunk0 = key[RAM_ADDR-1:0]).
- Pipeline: cycle N sample in_* into s1 (key, flag, hash). N+1: RAM read at s1 hash (read-first). N+2: s2 compares and writes. N+3: out_valid=1 for exactly one cycle with out_flag.
- Hit: entry.valid && entry.key==key (and not expired).
- Op SUSPECT (flag=?,01,1):
  - hit with SUSPECT -> no change; reply {1,01,1}.
  - hit with ARREST -> reply {1,10,1}; the parser blocks the packet on this reply.
  - miss -> write {1,SUSPECT,key}; reply {0,01,1}. If the slot held a valid entry with another key, increment the eviction counter.
- Op ARREST (flag=?,10,1):
  - hit -> write status ARREST; reply {1,11,1}. debug[4] is set.
  - miss -> no write; reply {0,00,1}.
- Any other flag value (op 00/11 or flag[0]=0) -> no write; reply {0,00,1}.
- Hazard: a write in cycle T to address A is held in a bypass register. If s2 in cycle T+1 holds address A, s2 uses the bypass entry instead of the RAM data. Back-to-back same-key requests therefore see each other's updates.
- A sweep write never coincides with a request write: requests are not written during INIT.
- Eviction counter saturates at 15.

Optional Feature:
KVS_AGING_EN:
- Defined:
  - A VAL_SIZE-bit free-running counter increments every cycle from 0 at reset.
  - Each written entry stores ts=counter, and a SUSPECT-op hit refreshes ts.
  - An entry with (counter-ts) mod 2^VAL_SIZE > AGE_TIMEOUT is treated as a miss; replacing it does not count as an eviction.
- Undefined: no timestamp field and no counter; entries persist until evicted or reset.

Test Plan:
1. Reset, then idle -> init_done=0 for 1024 cycles, then 1. A request at sweep cycle 5 -> out_flag=4'b0001 exactly 3 cycles later.
2. After init: SUSPECT key 96'h0A00_0001_0A00_0002_3039_0000 -> reply 4'b0011. Repeat -> 4'b1011. ARREST same key -> 4'b1111. SUSPECT again -> 4'b1101, debug[4]=1.
3. ARREST on never-inserted key 96'h5 -> 4'b0001, no state change. A later SUSPECT on 96'h5 -> 4'b0011.
4. Back-to-back: SUSPECT K at N, ARREST K at N+1, SUSPECT K at N+2 -> replies at N+3..N+5 of 4'b0011, 4'b1111, 4'b1101.
5. Collision: SUSPECT 96'h401, then SUSPECT 96'h802 (both hash 0) -> 4'b0011 each, debug[3:0]=1. SUSPECT 96'h401 -> 4'b0011 (miss), debug[3:0]=2.
6. With KVS_AGING_EN and AGE_TIMEOUT=100: SUSPECT K, wait 150 cycles, SUSPECT K -> 4'b0011 (expired, no eviction count). Without the macro, the same sequence -> 4'b1011.
